// File: rtl/atm_pkg.sv
// Shared types for the ATM session controller: FSM states, menu op codes, error codes.
package atm_pkg;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 4'd0,
        SCAN   = 4'd1,
        PIN    = 4'd2,
        MENU   = 4'd3,
        WDRAW  = 4'd4,
        SHOW   = 4'd5,
        DEP    = 4'd6,
        DONE   = 4'd7,
        NEXT   = 4'd8,
        ERROR  = 4'd9,
        RETAIN = 4'd10
    } atm_state_t;

    typedef enum logic [1:0] {
        OP_INV   = 2'b00,
        OP_WDRAW = 2'b01,
        OP_SHOW  = 2'b10,
        OP_DEP   = 2'b11
    } atm_op_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_AUTH    = 2'b01,
        ERR_FUNDS   = 2'b10,
        ERR_TIMEOUT = 2'b11
    } atm_err_t;

endpackage

// File: rtl/atm_timeout_ctr.sv
// Idle-cycle counter for the waiting states; expire flags the last allowed idle cycle.
module atm_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] count;

    // Saturates at the expiry value so a held enable never wraps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = enable && (count == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card/PIN/menu/transaction FSM owning the account balance.
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int unsigned BAL_W       = 12,
    parameter int unsigned AMT_W       = 8,
    parameter int unsigned PIN_W       = 16,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             card_in,
    input  logic             card_ok,
    input  logic             pin_valid,
    input  logic [PIN_W-1:0] pin,
    input  logic [PIN_W-1:0] pin_ref,
    input  logic             op_valid,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic             more,
    input  logic             bal_load,
    input  logic [BAL_W-1:0] bal_init,
    output logic [BAL_W-1:0] balance,
    output logic [3:0]       state,
    output logic [1:0]       err,
    output logic             done,
    output logic             card_retained
);

    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

    atm_state_t       cur_st, nxt_st;
    logic [TRY_W-1:0] tries, tries_nxt, tries_inc;
    logic [AMT_W-1:0] amt_q, amt_nxt;
    logic [BAL_W-1:0] bal_nxt;
    logic [1:0]       err_nxt;
    logic             done_nxt, ret_nxt;
    logic [BAL_W:0]   dep_sum;
    logic             pin_match, last_try, wd_ok, dep_carry;
    logic             waiting, strobe_acc, expire, tmr_clear;

    assign pin_match = (pin == pin_ref);
    assign tries_inc = tries + TRY_W'(1);
    assign last_try  = (tries_inc == TRY_W'(MAX_TRIES));
    assign wd_ok     = (BAL_W'(amt_q) <= balance);
    assign dep_sum   = {1'b0, balance} + (BAL_W + 1)'(amt_q);
    assign dep_carry = dep_sum[BAL_W];

    assign waiting    = (cur_st == PIN) || (cur_st == MENU) || (cur_st == NEXT);
    assign strobe_acc = ((cur_st == PIN) && pin_valid) ||
                        (((cur_st == MENU) || (cur_st == NEXT)) && op_valid);
    assign tmr_clear  = (nxt_st != cur_st) || strobe_acc;

    atm_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clear),
        .enable (waiting),
        .expire (expire)
    );

    // State and datapath registers; reset mid-session drops everything including balance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_st        <= IDLE;
            balance       <= '0;
            err           <= ERR_NONE;
            done          <= 1'b0;
            card_retained <= 1'b0;
            tries         <= '0;
            amt_q         <= '0;
        end else begin
            cur_st        <= nxt_st;
            balance       <= bal_nxt;
            err           <= err_nxt;
            done          <= done_nxt;
            card_retained <= ret_nxt;
            tries         <= tries_nxt;
            amt_q         <= amt_nxt;
        end
    end

    assign state = cur_st;

    // Next-state; a strobe always takes priority over a coincident timeout.
    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            IDLE:   if (card_in && !card_retained) nxt_st = SCAN;
            SCAN:   nxt_st = card_ok ? PIN : ERROR;
            PIN: begin
                if (pin_valid) begin
                    if (pin_match)     nxt_st = MENU;
                    else if (last_try) nxt_st = RETAIN;
                end else if (expire) begin
                    nxt_st = ERROR;
                end
            end
            MENU: begin
                if (op_valid) begin
                    case (op)
                        OP_WDRAW: nxt_st = WDRAW;
                        OP_SHOW:  nxt_st = SHOW;
                        OP_DEP:   nxt_st = DEP;
                        default:  nxt_st = ERROR;
                    endcase
                end else if (expire) begin
                    nxt_st = ERROR;
                end
            end
            WDRAW:  nxt_st = wd_ok ? DONE : ERROR;
            SHOW:   nxt_st = DONE;
            DEP:    nxt_st = dep_carry ? ERROR : DONE;
            DONE:   nxt_st = NEXT;
            NEXT: begin
                if (op_valid)    nxt_st = more ? MENU : IDLE;
                else if (expire) nxt_st = ERROR;
            end
            ERROR:  nxt_st = IDLE;
            RETAIN: nxt_st = IDLE;
            default: nxt_st = IDLE;
        endcase
    end

    // Register next-values; balance only moves on a legal withdraw/deposit or an IDLE load.
    always_comb begin
        bal_nxt   = balance;
        err_nxt   = err;
        tries_nxt = tries;
        amt_nxt   = amt_q;
        done_nxt  = (nxt_st == DONE);
        ret_nxt   = card_retained || (nxt_st == RETAIN);
        case (cur_st)
            IDLE: begin
                if (bal_load) bal_nxt = bal_init;
                if (nxt_st == SCAN) begin
                    err_nxt   = ERR_NONE;
                    tries_nxt = '0;
                end
            end
            SCAN: if (!card_ok) err_nxt = ERR_AUTH;
            PIN: begin
                if (pin_valid) begin
                    if (pin_match) begin
                        tries_nxt = '0;
                    end else begin
                        tries_nxt = tries_inc;
                        err_nxt   = ERR_AUTH;
                    end
                end else if (expire) begin
                    err_nxt = ERR_TIMEOUT;
                end
            end
            MENU: begin
                if (op_valid) begin
                    amt_nxt = amt;
                    if (op == OP_INV) err_nxt = ERR_AUTH;
                end else if (expire) begin
                    err_nxt = ERR_TIMEOUT;
                end
            end
            WDRAW: begin
                if (wd_ok) bal_nxt = balance - BAL_W'(amt_q);
                else       err_nxt = ERR_FUNDS;
            end
            DEP: begin
                if (dep_carry) err_nxt = ERR_FUNDS;
                else           bal_nxt = dep_sum[BAL_W-1:0];
            end
            NEXT: if (!op_valid && expire) err_nxt = ERR_TIMEOUT;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed self-checking bench for atm_session_ctrl at default parameters.
module tb_atm_session_ctrl;
    import atm_pkg::*;

    localparam int unsigned BAL_W = 12;
    localparam int unsigned AMT_W = 8;
    localparam int unsigned PIN_W = 16;
    localparam int unsigned TO    = 1024;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             card_in = 1'b0, card_ok = 1'b0, pin_valid = 1'b0;
    logic [PIN_W-1:0] pin = '0;
    logic [PIN_W-1:0] pin_ref = 16'h1234;
    logic             op_valid = 1'b0, more = 1'b0, bal_load = 1'b0;
    logic [1:0]       op = 2'b00;
    logic [AMT_W-1:0] amt = '0;
    logic [BAL_W-1:0] bal_init = '0;
    logic [BAL_W-1:0] balance;
    logic [3:0]       state;
    logic [1:0]       err;
    logic             done, card_retained;

    int n_cmp = 0;
    int n_err = 0;

    atm_session_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .card_in       (card_in),
        .card_ok       (card_ok),
        .pin_valid     (pin_valid),
        .pin           (pin),
        .pin_ref       (pin_ref),
        .op_valid      (op_valid),
        .op            (op),
        .amt           (amt),
        .more          (more),
        .bal_load      (bal_load),
        .bal_init      (bal_init),
        .balance       (balance),
        .state         (state),
        .err           (err),
        .done          (done),
        .card_retained (card_retained)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input atm_state_t exp);
        chk(tag, 32'(state), 32'(exp));
    endtask

    task automatic load_bal(input logic [BAL_W-1:0] v);
        bal_init = v; bal_load = 1'b1; step(); bal_load = 1'b0;
        chk("bal_load", 32'(balance), 32'(v));
    endtask

    // Card in, scan ok, correct PIN: ends in MENU.
    task automatic open_session();
        card_in = 1'b1; step(); card_in = 1'b0;
        chk_st("to_scan", SCAN);
        card_ok = 1'b1; step(); card_ok = 1'b0;
        chk_st("to_pin", PIN);
        pin = pin_ref; pin_valid = 1'b1; step(); pin_valid = 1'b0;
        chk_st("to_menu", MENU);
    endtask

    task automatic menu_op(input logic [1:0] o, input logic [AMT_W-1:0] a);
        op = o; amt = a; op_valid = 1'b1; step(); op_valid = 1'b0;
    endtask

    task automatic next_sel(input logic m);
        more = m; op_valid = 1'b1; step(); op_valid = 1'b0; more = 1'b0;
    endtask

    initial begin
        // Reset state
        step(); step();
        chk_st("rst_state", IDLE);
        chk("rst_bal", 32'(balance), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ret", 32'(card_retained), 32'd0);
        rst = 1'b1;

        // Withdraw 40 from 100
        load_bal(12'd100);
        open_session();
        menu_op(2'b01, 8'd40);
        chk_st("wd_state", WDRAW);
        step();
        chk_st("wd_done_st", DONE);
        chk("wd_bal", 32'(balance), 32'd60);
        chk("wd_done", 32'(done), 32'd1);
        step();
        chk_st("wd_next", NEXT);
        chk("wd_done_pulse", 32'(done), 32'd0);
        next_sel(1'b0);
        chk_st("wd_idle", IDLE);

        // Overdraw by one, then exact-balance withdraw, then balance enquiry
        open_session();
        menu_op(2'b01, 8'd61);
        step();
        chk_st("od_err_st", ERROR);
        chk("od_err", 32'(err), 32'd2);
        chk("od_bal", 32'(balance), 32'd60);
        step();
        chk_st("od_idle", IDLE);
        chk("od_err_held", 32'(err), 32'd2);
        card_in = 1'b1; step(); card_in = 1'b0;
        chk("err_clear", 32'(err), 32'd0);
        card_ok = 1'b1; step(); card_ok = 1'b0;
        pin = pin_ref; pin_valid = 1'b1; step(); pin_valid = 1'b0;
        menu_op(2'b01, 8'd60);
        step();
        chk("wd_all_bal", 32'(balance), 32'd0);
        chk("wd_all_done", 32'(done), 32'd1);
        step();
        next_sel(1'b1);
        chk_st("more_menu", MENU);
        menu_op(2'b10, 8'd0);
        chk_st("show_st", SHOW);
        step();
        chk("show_done", 32'(done), 32'd1);
        chk("show_bal", 32'(balance), 32'd0);
        step();
        next_sel(1'b0);

        // Deposit overflow and deposit to full scale
        load_bal(12'd4090);
        open_session();
        menu_op(2'b11, 8'd10);
        chk_st("dep_st", DEP);
        step();
        chk_st("dep_ovf_st", ERROR);
        chk("dep_ovf_err", 32'(err), 32'd2);
        chk("dep_ovf_bal", 32'(balance), 32'd4090);
        step();
        open_session();
        menu_op(2'b11, 8'd5);
        step();
        chk("dep_bal", 32'(balance), 32'd4095);
        chk("dep_done", 32'(done), 32'd1);
        step();
        next_sel(1'b0);

        // Invalid op code
        open_session();
        menu_op(2'b00, 8'd0);
        chk_st("inv_op_st", ERROR);
        chk("inv_op_err", 32'(err), 32'd1);
        step();

        // Three wrong PINs retain the card
        card_in = 1'b1; step(); card_in = 1'b0;
        card_ok = 1'b1; step(); card_ok = 1'b0;
        pin = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            pin_valid = 1'b1; step(); pin_valid = 1'b0;
            chk_st("bad_pin_st", PIN);
            chk("bad_pin_err", 32'(err), 32'd1);
            step();
        end
        pin_valid = 1'b1; step(); pin_valid = 1'b0;
        chk_st("retain_st", RETAIN);
        chk("retain_flag", 32'(card_retained), 32'd1);
        step();
        chk_st("retain_idle", IDLE);
        card_in = 1'b1; step(); step(); card_in = 1'b0;
        chk_st("retain_ignore", IDLE);
        chk("retain_sticky", 32'(card_retained), 32'd1);
        rst = 1'b0; step(); rst = 1'b1;
        chk("retain_rst", 32'(card_retained), 32'd0);

        // MENU timeout, then a strobe on the expiry cycle
        load_bal(12'd50);
        open_session();
        for (int i = 0; i < int'(TO) - 1; i++) step();
        chk_st("to_last_wait", MENU);
        step();
        chk_st("to_err_st", ERROR);
        chk("to_err", 32'(err), 32'd3);
        step();
        chk_st("to_idle", IDLE);
        chk("to_err_held", 32'(err), 32'd3);
        open_session();
        for (int i = 0; i < int'(TO) - 1; i++) step();
        menu_op(2'b10, 8'd0);
        chk_st("to_strobe_wins", SHOW);
        step();
        chk("to_strobe_done", 32'(done), 32'd1);
        chk("to_strobe_bal", 32'(balance), 32'd50);
        step();
        next_sel(1'b0);

        // Reset in the middle of a withdrawal
        open_session();
        menu_op(2'b01, 8'd10);
        chk_st("mid_wd_st", WDRAW);
        rst = 1'b0; step(); rst = 1'b1;
        chk_st("mid_rst_st", IDLE);
        chk("mid_rst_bal", 32'(balance), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
